// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer states, opcodes and control-word bit indices.
// Used by the control unit and by PC and the other datapath blocks.
package cpu_pkg;

    localparam int CTRL_W   = 32;
    localparam int OPCODE_W = 8;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_DEC,
        S_ADDR, S_RD, S_LDA, S_BR, S_ALU,
        S_WB, S_WR, S_JMP, S_END, S_HALT
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_STORE  = 8'h01;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 8'h02;
    localparam logic [OPCODE_W-1:0] OP_ADD    = 8'h03;
    localparam logic [OPCODE_W-1:0] OP_SUB    = 8'h04;
    localparam logic [OPCODE_W-1:0] OP_JMPGEZ = 8'h05;
    localparam logic [OPCODE_W-1:0] OP_JMP    = 8'h06;
    localparam logic [OPCODE_W-1:0] OP_HALT   = 8'h07;
    localparam logic [OPCODE_W-1:0] OP_AND    = 8'h0A;
    localparam logic [OPCODE_W-1:0] OP_OR     = 8'h0B;
    localparam logic [OPCODE_W-1:0] OP_NOT    = 8'h0C;
    localparam logic [OPCODE_W-1:0] OP_SHR    = 8'h0D;
    localparam logic [OPCODE_W-1:0] OP_SHL    = 8'h0E;

    localparam int C_PC_MAR  = 0;
    localparam int C_MEM_MBR = 1;
    localparam int C_MBR_IR  = 2;
    localparam int C_IR_MAR  = 3;
    localparam int C_MBR_MEM = 4;
    localparam int C_ACC_MBR = 5;
    localparam int C_PC_INC  = 6;
    localparam int C_MBR_BR  = 7;
    localparam int C_ADD     = 8;
    localparam int C_SUB     = 9;
    localparam int C_AND     = 10;
    localparam int C_OR      = 11;
    localparam int C_NOT     = 12;
    localparam int C_SHR     = 13;
    localparam int C_SHL     = 14;
    localparam int C_ALU_ACC = 15;
    localparam int C_MBR_ACC = 16;
    localparam int C_MBR_PC  = 21;

    function automatic logic [CTRL_W-1:0] cbit(input int unsigned idx);
        return CTRL_W'(1) << idx;
    endfunction

    function automatic logic [CTRL_W-1:0] alu_sel(
        input logic [OPCODE_W-1:0] op
    );
        logic [CTRL_W-1:0] w;
        w = '0;
        unique case (op)
            OP_ADD:  w = cbit(C_ADD);
            OP_SUB:  w = cbit(C_SUB);
            OP_AND:  w = cbit(C_AND);
            OP_OR:   w = cbit(C_OR);
            OP_NOT:  w = cbit(C_NOT);
            OP_SHR:  w = cbit(C_SHR);
            OP_SHL:  w = cbit(C_SHL);
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: registered state (plus latched IR opcode for the ALU
// select) to control word and memory strobes.
module ctrl_decode
    import cpu_pkg::*;
(
    input  state_t              state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic                mem_req_o,
    output logic                mem_we_o
);

    always_comb begin
        ctrl_o    = '0;
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        unique case (state_i)
            S_F0:   ctrl_o = cbit(C_PC_MAR);
            S_F1: begin
                ctrl_o    = cbit(C_MEM_MBR);
                mem_req_o = 1'b1;
            end
            S_F2:   ctrl_o = cbit(C_MBR_IR) | cbit(C_PC_INC);
            S_ADDR: ctrl_o = cbit(C_IR_MAR);
            S_RD: begin
                ctrl_o    = cbit(C_MEM_MBR);
                mem_req_o = 1'b1;
            end
            S_LDA:  ctrl_o = cbit(C_MBR_ACC);
            S_BR:   ctrl_o = cbit(C_MBR_BR);
            S_ALU:  ctrl_o = alu_sel(opcode_i) | cbit(C_ALU_ACC);
            S_WB:   ctrl_o = cbit(C_ACC_MBR);
            S_WR: begin
                ctrl_o    = cbit(C_MBR_MEM);
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
            end
            S_JMP:  ctrl_o = cbit(C_MBR_PC);
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Microsequencer: fetch/decode/execute state register, memory-wait
// timeout counter and sticky bus-error flag.
module control_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                acc_neg,
    input  logic                mem_ready,
    output logic [CTRL_W-1:0]   control_signal,
    output logic                mem_req,
    output logic                mem_we,
    output logic                halted,
    output logic                illegal_op,
    output logic                bus_error
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             berr_q, berr_d;
    logic             ill_q, ill_d;
    logic             wait_st;
    logic             at_max;

    assign wait_st = state_q inside {S_F1, S_RD, S_WR};
    assign at_max  = (cnt_q == CNT_W'(WAIT_MAX));

    always_comb begin
        state_d = state_q;
        berr_d  = berr_q;
        ill_d   = 1'b0;
        unique case (state_q)
            S_IDLE: if (run) state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F2:   state_d = S_DEC;
            S_DEC: begin
                unique case (ir_opcode)
                    OP_STORE, OP_LOAD, OP_ADD,
                    OP_SUB, OP_AND, OP_OR:
                        state_d = S_ADDR;
                    OP_NOT, OP_SHR, OP_SHL:
                        state_d = S_ALU;
                    OP_JMPGEZ:
                        state_d = acc_neg ? S_END : S_JMP;
                    OP_JMP:  state_d = S_JMP;
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        ill_d   = 1'b1;
                        state_d = S_END;
                    end
                endcase
            end
            S_ADDR: begin
                state_d = (ir_opcode == OP_STORE) ? S_WB : S_RD;
            end
            S_F1, S_RD, S_WR: begin
                // a ready pulse on the last allowed cycle still wins
                if (mem_ready) begin
                    unique case (state_q)
                        S_F1:    state_d = S_F2;
                        S_RD:    state_d = (ir_opcode == OP_LOAD)
                                           ? S_LDA : S_BR;
                        default: state_d = S_END;
                    endcase
                end else if (at_max) begin
                    state_d = S_HALT;
                    berr_d  = 1'b1;
                end
            end
            S_BR:   state_d = S_ALU;
            S_WB:   state_d = S_WR;
            S_LDA, S_ALU, S_JMP:
                state_d = S_END;
            S_END:  state_d = run ? S_F0 : S_IDLE;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt_d = (wait_st && state_d == state_q)
                   ? cnt_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            berr_q  <= berr_d;
            ill_q   <= ill_d;
        end
    end

    ctrl_decode u_dec (
        .state_i   (state_q),
        .opcode_i  (ir_opcode),
        .ctrl_o    (control_signal),
        .mem_req_o (mem_req),
        .mem_we_o  (mem_we)
    );

    assign halted     = (state_q == S_HALT);
    assign illegal_op = ill_q;
    assign bus_error  = berr_q;

endmodule

// File: tb/tb_control_unit.sv
// Cycle-accurate scoreboard bench for control_unit: per-instruction
// vector table plus halt, timeout, run-drop and async-reset sequences.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [7:0]  ir_opcode;
    logic        acc_neg;
    logic        mem_ready;
    logic [31:0] control_signal;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic        illegal_op;
    logic        bus_error;

    control_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .ir_opcode      (ir_opcode),
        .acc_neg        (acc_neg),
        .mem_ready      (mem_ready),
        .control_signal (control_signal),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .halted         (halted),
        .illegal_op     (illegal_op),
        .bus_error      (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cw;
        logic        req, we, hlt, ill, be;
        logic        rdy, run;
        logic [7:0]  op;
        logic        neg;
        string       nm;
    } item_t;

    typedef struct {
        string       nm;
        logic [7:0]  op;
        logic        neg;
        int          fd, ed;
        logic        noise;
        int          n;
        logic [31:0] e0, e1, e2, e3;
        int          wt;
        logic        ill;
    } vec_t;

    item_t      q[$];
    vec_t       vt[16];
    int         total = 0;
    int         bad   = 0;
    logic       cur_run;
    logic [7:0] cur_op;
    logic       cur_neg;
    string      cur_nm;

    function automatic logic [31:0] cb(input int i);
        return 32'(1) << i;
    endfunction

    function automatic vec_t mk(
        input string nm, input logic [7:0] op, input logic neg,
        input int fd, input int ed, input logic noise, input int n,
        input logic [31:0] e0, input logic [31:0] e1,
        input logic [31:0] e2, input logic [31:0] e3,
        input int wt, input logic ill);
        vec_t v;
        v.nm = nm; v.op = op; v.neg = neg; v.fd = fd; v.ed = ed;
        v.noise = noise; v.n = n; v.e0 = e0; v.e1 = e1;
        v.e2 = e2; v.e3 = e3; v.wt = wt; v.ill = ill;
        return v;
    endfunction

    function automatic logic [31:0] pick(input vec_t v, input int k);
        case (k)
            0: return v.e0;
            1: return v.e1;
            2: return v.e2;
            default: return v.e3;
        endcase
    endfunction

    task automatic push(input logic [31:0] cw, input logic req,
                        input logic we, input logic hlt, input logic ill,
                        input logic be, input logic rdy);
        item_t it;
        it.cw = cw; it.req = req; it.we = we; it.hlt = hlt;
        it.ill = ill; it.be = be; it.rdy = rdy; it.run = cur_run;
        it.op = cur_op; it.neg = cur_neg; it.nm = cur_nm;
        q.push_back(it);
    endtask

    task automatic push_fetch(input int fd, input logic noise);
        push(cb(0), 0, 0, 0, 0, 0, noise);
        for (int j = 0; j < fd; j++)
            push(cb(1), 1, 0, 0, 0, 0, j == fd - 1);
        push(cb(2) | cb(6), 0, 0, 0, 0, 0, noise);
        push(32'h0, 0, 0, 0, 0, 0, noise);
    endtask

    task automatic push_instr(input vec_t v);
        logic [31:0] w;
        cur_op = v.op; cur_neg = v.neg; cur_nm = v.nm;
        push_fetch(v.fd, v.noise);
        for (int k = 0; k < v.n; k++) begin
            w = pick(v, k);
            if (k == v.wt) begin
                for (int j = 0; j < v.ed; j++)
                    push(w, 1, w == cb(4), 0, 0, 0, j == v.ed - 1);
            end else begin
                push(w, 0, 0, 0, 0, 0, v.noise);
            end
        end
        push(32'h0, 0, 0, 0, v.ill, 0, v.noise);
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic drain();
        item_t it;
        logic [36:0] got, exp;
        int cyc;
        cyc = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            run = it.run; ir_opcode = it.op;
            acc_neg = it.neg; mem_ready = it.rdy;
            #1;
            got = {control_signal, mem_req, mem_we,
                   halted, illegal_op, bus_error};
            exp = {it.cw, it.req, it.we, it.hlt, it.ill, it.be};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cyc%0d got=%h want=%h",
                         it.nm, cyc, got, exp);
            end
            cyc++;
            @(negedge clk);
        end
        mem_ready = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        logic [36:0] got;
        got = {control_signal, mem_req, mem_we,
               halted, illegal_op, bus_error};
        total++;
        if (got !== 37'h0) begin
            bad++;
            $display("FAIL %s got=%h want=0", nm, got);
        end
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        #1;
        chk_zero(nm);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; ir_opcode = 8'h00;
        acc_neg = 1'b0; mem_ready = 1'b0;
        cur_run = 1'b1; cur_op = 8'h00; cur_neg = 1'b0;
        cur_nm = "idle";

        vt[0]  = mk("jmp", 8'h06, 0, 2, 0, 0, 1,
                    cb(21), 0, 0, 0, -1, 0);
        vt[1]  = mk("add", 8'h03, 0, 1, 5, 0, 4,
                    cb(3), cb(1), cb(7), cb(8) | cb(15), 1, 0);
        vt[2]  = mk("store", 8'h01, 0, 1, 3, 0, 3,
                    cb(3), cb(5), cb(4), 0, 2, 0);
        vt[3]  = mk("jgez_neg", 8'h05, 1, 1, 0, 0, 0,
                    0, 0, 0, 0, -1, 0);
        vt[4]  = mk("jgez_pos", 8'h05, 0, 1, 0, 0, 1,
                    cb(21), 0, 0, 0, -1, 0);
        vt[5]  = mk("illegal_ff", 8'hFF, 0, 1, 0, 0, 0,
                    0, 0, 0, 0, -1, 1);
        vt[6]  = mk("load", 8'h02, 1, 2, 2, 0, 3,
                    cb(3), cb(1), cb(16), 0, 1, 0);
        vt[7]  = mk("sub", 8'h04, 0, 1, 1, 0, 4,
                    cb(3), cb(1), cb(7), cb(9) | cb(15), 1, 0);
        vt[8]  = mk("and", 8'h0A, 0, 1, 2, 0, 4,
                    cb(3), cb(1), cb(7), cb(10) | cb(15), 1, 0);
        vt[9]  = mk("or", 8'h0B, 0, 3, 1, 0, 4,
                    cb(3), cb(1), cb(7), cb(11) | cb(15), 1, 0);
        vt[10] = mk("not_noise", 8'h0C, 0, 1, 0, 1, 1,
                    cb(12) | cb(15), 0, 0, 0, -1, 0);
        vt[11] = mk("shr", 8'h0D, 0, 1, 0, 0, 1,
                    cb(13) | cb(15), 0, 0, 0, -1, 0);
        vt[12] = mk("shl", 8'h0E, 1, 1, 0, 0, 1,
                    cb(14) | cb(15), 0, 0, 0, -1, 0);
        vt[13] = mk("f1_edge16", 8'h06, 0, 16, 0, 0, 1,
                    cb(21), 0, 0, 0, -1, 0);
        vt[14] = mk("rd_edge16", 8'h03, 0, 1, 16, 0, 4,
                    cb(3), cb(1), cb(7), cb(8) | cb(15), 1, 0);
        vt[15] = mk("illegal_00", 8'h00, 0, 1, 0, 0, 0,
                    0, 0, 0, 0, -1, 1);

        #3;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h0, 0, 0, 0, 0, 0, 0);
        drain();

        for (int i = 0; i < 16; i++) begin
            push_instr(vt[i]);
            drain();
        end

        cur_op = 8'h0C; cur_nm = "run_drop";
        push_fetch(1, 0);
        cur_run = 1'b0;
        push(cb(12) | cb(15), 0, 0, 0, 0, 0, 0);
        push(32'h0, 0, 0, 0, 0, 0, 0);
        push(32'h0, 0, 0, 0, 0, 0, 0);
        push(32'h0, 0, 0, 0, 0, 0, 0);
        cur_run = 1'b1;
        push(32'h0, 0, 0, 0, 0, 0, 0);
        drain();

        cur_op = 8'h07; cur_nm = "halt";
        push_fetch(1, 0);
        for (int j = 0; j < 100; j++)
            push(32'h0, 0, 0, 1, 0, 0, j[0]);
        drain();

        do_reset("reset_after_halt");
        cur_op = 8'h06; cur_nm = "bus_err";
        push(32'h0, 0, 0, 0, 0, 0, 0);
        push(cb(0), 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 16; j++)
            push(cb(1), 1, 0, 0, 0, 0, 0);
        for (int j = 0; j < 3; j++)
            push(32'h0, 0, 0, 1, 0, 1, 1);
        drain();

        do_reset("reset_after_berr");
        cur_op = 8'h01; cur_nm = "wr_abort";
        push(32'h0, 0, 0, 0, 0, 0, 0);
        push_fetch(1, 0);
        push(cb(3), 0, 0, 0, 0, 0, 0);
        push(cb(5), 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 3; j++)
            push(cb(4), 1, 1, 0, 0, 0, 0);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst_wr");
        @(negedge clk);
        rst_n = 1'b1;
        cur_run = 1'b0; cur_nm = "idle_after_rst";
        push(32'h0, 0, 0, 0, 0, 0, 0);
        push(32'h0, 0, 0, 0, 0, 0, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
